// File: rtl/seg_pkg.sv
// Shared types, constants and hex-to-7-segment decode for the segment scan driver.
// All segment encodings are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] digit_t;

    localparam seg7_t      SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    function automatic seg7_t hex7(input digit_t v);
        seg7_t s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_tx_sync.sv
// Two-flop synchronizer for the asynchronous write strobe, followed by a
// rising-edge detector that yields a single-cycle pulse per strobe.
module seg_tx_sync (
    input  logic clk,
    input  logic clr_n,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit display memory with time-multiplexed common-anode 7-segment scan.
// Optional leading-zero blanking is enabled by defining SEG_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DIGITS   = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] nom_in,
    input  logic [1:0] bit_in,
    input  logic [3:0] le_in,
    input  logic       tx_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = $clog2(PRESCALE);

    if (DIGITS != 4) begin : g_bad_digits
        $error("seg_scan_driver supports exactly 4 digits");
    end
    if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
        $error("seg_scan_driver PRESCALE out of range 2..65535");
    end

    logic          wr_stb;
    digit_t        digit_q [4];
    logic [1:0]    cursor_q;
    logic [PW-1:0] pre_q;
    logic [1:0]    scan_idx_q;
    logic          tick;
    seg7_t         seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          blank;

    seg_tx_sync u_tx_sync (
        .clk     (clk),
        .clr_n   (clr_n),
        .async_i (tx_in),
        .rise_o  (wr_stb)
    );

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            cursor_q   <= '0;
            pre_q      <= '0;
            scan_idx_q <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= AN_OFF;
            dp_q       <= 1'b1;
        end else begin
            if (wr_stb) begin
                digit_q[bit_in] <= nom_in;
                cursor_q        <= bit_in;
            end
            pre_q      <= tick ? '0 : pre_q + 1'b1;
            scan_idx_q <= tick ? scan_idx_q + 2'd1 : scan_idx_q;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
        end
    end

`ifdef SEG_ZERO_BLANK_EN
    // zero_run[i]: digit i and every digit above it hold zero
    logic [3:0] zero_run;
    always_comb begin
        zero_run    = '0;
        zero_run[3] = (digit_q[3] == 4'h0);
        zero_run[2] = zero_run[3] && (digit_q[2] == 4'h0);
        zero_run[1] = zero_run[2] && (digit_q[1] == 4'h0);
        blank       = (scan_idx_q != 2'd0) && zero_run[scan_idx_q];
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        dp_d  = 1'b1;
        if (le_in[scan_idx_q]) begin
            an_d  = ~(4'b0001 << scan_idx_q);
            seg_d = blank ? SEG_BLANK : hex7(digit_q[scan_idx_q]);
            dp_d  = ~(cursor_q == scan_idx_q);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with PRESCALE=4.
module tb_seg_scan_driver;

    logic       clk;
    logic       clr_n;
    logic [3:0] nom_in;
    logic [1:0] bit_in;
    logic [3:0] le_in;
    logic       tx_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks;
    int errors;

`ifdef SEG_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    seg_scan_driver #(.PRESCALE(4), .DIGITS(4)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .nom_in (nom_in),
        .bit_in (bit_in),
        .le_in  (le_in),
        .tx_in  (tx_in),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_digit(input logic [3:0] v, input logic [1:0] idx);
        @(negedge clk);
        nom_in = v;
        bit_in = idx;
        tx_in  = 1'b1;
        repeat (2) @(negedge clk);
        tx_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_digit(input string name, input logic [1:0] idx,
                               input logic [6:0] exp_seg, input logic exp_dp);
        logic [3:0] want_an;
        bit found;
        want_an = ~(4'b0001 << idx);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === want_an) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: timeout waiting an=%h, last an=%h", name, want_an, an);
        end else begin
            if (seg !== exp_seg) begin
                errors++;
                $display("FAIL %s seg: got %h expected %h", name, seg, exp_seg);
            end
            checks++;
            if (dp !== exp_dp) begin
                errors++;
                $display("FAIL %s dp: got %b expected %b", name, dp, exp_dp);
            end
        end
    endtask

    task automatic test_reset;
        clr_n  = 1'b0;
        le_in  = 4'hF;
        tx_in  = 1'b0;
        nom_in = 4'h0;
        bit_in = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({seg, an, dp} !== {7'h7F, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got seg=%h an=%h dp=%b expected 7f f 1", seg, an, dp);
        end
    endtask

    task automatic test_scan_order;
        logic [3:0] exp_an;
        clr_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL scan_an[%0d]: got %h expected %h", k, an, exp_an);
            end
            if (k == 0) begin
                checks++;
                if (seg !== 7'h40 || dp !== 1'b0) begin
                    errors++;
                    $display("FAIL first_update: got seg=%h dp=%b expected 40 0", seg, dp);
                end
            end
        end
    endtask

    task automatic test_single_write;
        write_digit(4'hA, 2'd2);
        check_digit("wr_d2", 2'd2, 7'h08, 1'b0);
        check_digit("wr_d0", 2'd0, 7'h40, 1'b1);
        check_digit("wr_d1", 2'd1, 7'h40, 1'b1);
        check_digit("wr_d3", 2'd3, ZB ? 7'h7F : 7'h40, 1'b1);
    endtask

    task automatic test_held_strobe;
        write_digit(4'hF, 2'd0);
        write_digit(4'h3, 2'd1);
        write_digit(4'h0, 2'd2);
        write_digit(4'h7, 2'd3);
        @(negedge clk);
        nom_in = 4'h5;
        bit_in = 2'd0;
        tx_in  = 1'b1;
        repeat (6) @(negedge clk);
        nom_in = 4'h9;
        bit_in = 2'd1;
        repeat (14) @(negedge clk);
        tx_in = 1'b0;
        repeat (4) @(negedge clk);
        check_digit("held_d0", 2'd0, 7'h12, 1'b0);
        check_digit("held_d1", 2'd1, 7'h30, 1'b1);
        check_digit("held_d2", 2'd2, 7'h40, 1'b1);
        check_digit("held_d3", 2'd3, 7'h78, 1'b1);
    endtask

    task automatic test_enable_mask;
        int n_off, n_e, n_b, n_bad;
        n_off = 0; n_e = 0; n_b = 0; n_bad = 0;
        @(negedge clk);
        le_in = 4'b0101;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an === 4'hF) begin
                n_off++;
                if (seg !== 7'h7F || dp !== 1'b1) n_bad++;
            end else if (an === 4'hE) n_e++;
            else if (an === 4'hB) n_b++;
            else n_bad++;
        end
        checks++;
        if (n_off != 8 || n_e != 4 || n_b != 4 || n_bad != 0) begin
            errors++;
            $display("FAIL le_mask: got off=%0d e=%0d b=%0d bad=%0d expected 8 4 4 0",
                     n_off, n_e, n_b, n_bad);
        end
        check_digit("le_d0", 2'd0, 7'h12, 1'b0);
        check_digit("le_d2", 2'd2, 7'h40, 1'b1);
        le_in = 4'hF;
    endtask

    task automatic test_reset_mid_write;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === 4'hB) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_sync: timeout waiting an=b, last an=%h", an);
        end
        nom_in = 4'hE;
        bit_in = 2'd1;
        tx_in  = 1'b1;
        @(negedge clk);
        clr_n = 1'b0;
        tx_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({seg, an, dp} !== {7'h7F, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_out: got seg=%h an=%h dp=%b expected 7f f 1", seg, an, dp);
        end
        clr_n = 1'b1;
        repeat (6) @(negedge clk);
        check_digit("rst_d0", 2'd0, 7'h40, 1'b0);
        check_digit("rst_d1", 2'd1, ZB ? 7'h7F : 7'h40, 1'b1);
        check_digit("rst_d2", 2'd2, ZB ? 7'h7F : 7'h40, 1'b1);
        check_digit("rst_d3", 2'd3, ZB ? 7'h7F : 7'h40, 1'b1);
    endtask

`ifdef SEG_ZERO_BLANK_EN
    task automatic test_zero_blank;
        write_digit(4'h4, 2'd1);
        check_digit("zb_d3", 2'd3, 7'h7F, 1'b1);
        check_digit("zb_d2", 2'd2, 7'h7F, 1'b1);
        check_digit("zb_d1", 2'd1, 7'h19, 1'b0);
        check_digit("zb_d0", 2'd0, 7'h40, 1'b1);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_scan_order;
        test_single_write;
        test_held_strobe;
        test_enable_mask;
        test_reset_mid_write;
`ifdef SEG_ZERO_BLANK_EN
        test_zero_blank;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
